// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that issues to it.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;
endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's complement; used for operand magnitudes and result sign fix-up.
module twos_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);
  assign result = negate ? (~value + W'(1)) : value;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int ITER = (WIDTH == MDU_WIDTH) ? MDU_ITER : WIDTH;

  mdu_state_e         state;
  mdu_op_e            op_q;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r, b_zero;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               accept, signed_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_next;
  logic [WIDTH+1:0]   rem_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = (state == IDLE) && start;
  assign signed_in = ~op[0];

  // 0x80000000 stays 0x80000000 after negation and is read as unsigned 2^31.
  twos_abs_neg #(.W(WIDTH)) u_abs_a (.value(a), .negate(signed_in & a[WIDTH-1]), .result(a_mag));
  twos_abs_neg #(.W(WIDTH)) u_abs_b (.value(b), .negate(signed_in & b[WIDTH-1]), .result(b_mag));

  // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: dividend bits leave acc MSB-first, quotient bits enter at the LSB.
  assign rem_sh   = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, mcand};
  assign div_ok   = ~rem_diff[WIDTH+1];
  assign div_q    = {acc[WIDTH-2:0], div_ok};
  assign rem_next = div_ok ? rem_diff[WIDTH:0] : rem_sh;

  twos_abs_neg #(.W(2*WIDTH)) u_fix_prod (.value(acc), .negate(sign_q), .result(prod_fix));
  twos_abs_neg #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .negate(sign_q), .result(quo_fix));
  twos_abs_neg #(.W(WIDTH)) u_fix_rem (.value(rem[WIDTH-1:0]), .negate(sign_r), .result(rem_fix));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= OP_MULT;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= mdu_op_e'(op);
            sign_q <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= signed_in & a[WIDTH-1];
            b_zero <= (b == '0);
            cnt    <= CNT_W'(ITER);
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            if (mthi_en) hi <= wdata;
            if (mtlo_en) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (op_q[1]) begin
            if (b_zero) begin
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem <= '0;
      if (op[1]) begin
        mcand <= b_mag;
        acc   <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        mcand <= a_mag;
        acc   <= {{WIDTH{1'b0}}, b_mag};
      end
    end else if (state == RUN) begin
      if (op_q[1]) begin
        acc[WIDTH-1:0] <= div_q;
        rem            <= rem_next;
      end else begin
        acc <= mul_next;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi_en = 1'b0, mtlo_en = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && busy) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for busy to drop; optionally poke MTLO and a second start mid-op.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, output int cyc, output logic d, output logic z);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (inject && cyc == 5) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        mtlo_en = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; mtlo_en = 1'b0;
      end
      cyc++;
      tick();
    end
    start = 1'b0; mtlo_en = 1'b0;
    d = done;
    z = div_zero;
    tick();
  endtask

  int   cyc, base;
  logic d, z;

  initial begin
    tick(); tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {done, div_zero}, 0);
    reset = 1'b1;
    tick();

    base = done_cnt;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, cyc, d, z);
    check("multu_busy_cycles", cyc, 33);
    check("multu_done", {d, z}, 2'b10);
    check("multu_done_count", done_cnt - base, 1);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, cyc, d, z);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(OP_MULT, 32'h80000000, 32'h80000000, 0, cyc, d, z);
    check("mult_min_hilo", {hi, lo}, 64'h40000000_00000000);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, cyc, d, z);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, cyc, d, z);
    check("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, cyc, d, z);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    mthi_en = 1'b1; wdata = 32'h11111111;
    tick();
    mthi_en = 1'b0; mtlo_en = 1'b1; wdata = 32'h22222222;
    tick();
    mtlo_en = 1'b0;
    check("mt_preload", {hi, lo}, 64'h11111111_22222222);
    run_op(OP_DIVU, 32'd100, 32'd0, 0, cyc, d, z);
    check("dz_cycles", cyc, 33);
    check("dz_pulses", {d, z}, 2'b11);
    check("dz_hilo_kept", {hi, lo}, 64'h11111111_22222222);

    mthi_en = 1'b1; wdata = 32'h12345678;
    tick();
    mthi_en = 1'b0;
    check("mthi_idle", hi, 32'h12345678);
    base = done_cnt;
    run_op(OP_MULTU, 32'h00010000, 32'h00010001, 1, cyc, d, z);
    check("busy_inject_cycles", cyc, 33);
    check("busy_inject_hilo", {hi, lo}, 64'h00000001_00010000);
    repeat (40) tick();
    check("busy_inject_done_count", done_cnt - base, 1);
    check("busy_inject_idle", busy, 0);

    base = done_cnt;
    op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_hilo", {hi, lo}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) tick();
    check("abandoned_no_done", done_cnt - base, 0);
    run_op(OP_MULTU, 32'd5, 32'd6, 0, cyc, d, z);
    check("after_rst_hilo", {hi, lo}, {32'd0, 32'd30});
    check("done_busy_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- The combinational ALU stops computing MULT/MULTU/DIV/DIVU and stops holding HI/LO. The decode stage issues those ops here.
- The CPU reads HI/LO from here for MFHI/MFLO and writes them here for MTHI/MTLO.
- busy stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width (holds 0..WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue request, sampled on rising clk.
- op  in  2  operation select: MULT, MULTU, DIV, DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- mthi_en  in  1  write wdata to HI.
- mtlo_en  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse, HI/LO just updated by an op.
- div_zero  out  1  one-cycle pulse with done, divisor was zero.

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. An in-flight op is abandoned and produces no done.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch sign_q=a[31]^b[31] and sign_r=a[31] (signed only).
  - Counter=WIDTH; go to RUN.
- RUN, one iteration per cycle, counter decrements, leave RUN when counter reaches 0 (edge E0+32):
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring divide; 33-bit partial remainder, quotient shifted in LSB-first from the dividend.
- FIX, edge E0+33:
  - Apply sign correction: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write HI/LO and return to IDLE.
- done and div_zero are registered and high for exactly the cycle after edge E0+33.
- busy is 1 from after E0 through edge E0+33, i.e. 33 cycles.
- Result mapping:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
  - Signed divide truncates toward zero; remainder takes the sign of the dividend.
- Width rule: 0x80000000 is handled as magnitude 2^31 (unsigned 32-bit). DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (b==0 latched at start): the op still takes 33 cycles, HI/LO are left unchanged, and div_zero pulses with done.
- start while busy: ignored. The CPU must not issue it.
- op is only sampled with an accepted start.
- mthi_en/mtlo_en:
  - In IDLE without start: the target register takes wdata at the edge, visible the next cycle. Both asserted writes both.
  - While busy, or in the same cycle as an accepted start: dropped.
- hi/lo are outputs driven directly from the registers. While busy they show the previous values.
- done never coincides with busy=1.

Decomposition:
- Shared package mdu_pkg:
  - typedef for op: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - typedef enum for state: IDLE, RUN, FIX.
  - constants MDU_WIDTH=32 and MDU_ITER=32.
  - The ALU control decoder imports the same op typedef.
- One combinational sub-module, twos_abs_neg:
  - Inputs: value, negate flag. Output: conditionally two's-complemented value.
  - Instantiated for operand magnitudes and for FIX-state result correction.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/7 -> LO=14, HI=2.
- Preload HI=0x11111111, LO=0x22222222 via MTHI/MTLO; DIVU 100/0 -> div_zero and done pulse together, HI/LO unchanged.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle. During busy: MTLO 0xDEADBEEF and a second start are both ignored; LO becomes the product, and only one done is seen.
- Start MULTU 5x6, pull reset low at cycle 10 for one cycle -> busy=0, hi=lo=0 immediately; no done. A new MULTU 5x6 then completes with LO=30, HI=0.
